// File: rtl/round_robin_burst_arbiter_if.sv
// Request/grant bundle for the round-robin burst arbiter.
// master drives requests, slave (the arbiter) returns grants.
interface round_robin_burst_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  REQ;
  logic [N-1:0]  GNT;
  logic [IW-1:0] GNT_ID;
  logic          BUSY;

  modport master (
    output REQ,
    input  GNT,
    input  GNT_ID,
    input  BUSY
  );

  modport slave (
    input  REQ,
    output GNT,
    output GNT_ID,
    output BUSY
  );
endinterface

// File: rtl/round_robin_burst_arbiter.sv
// Round-robin arbiter with bounded burst ownership.
// Grants are registered; priority rotates from the last owner.
module round_robin_burst_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input logic clk,
  input logic rstn,
  round_robin_burst_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t        state;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic [IW-1:0] last;
  logic [CW-1:0] cnt;

  logic          sel_vld;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          hold;

  // search starts one past the last owner and wraps,
  // so the last owner itself is considered last
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!sel_vld && bus.REQ[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  assign hold = bus.REQ[gnt_id] &&
                (cnt < CW'(MAX_BURST));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      cnt    <= '0;
      last   <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            state  <= OWNED;
            gnt    <= N'(1) << sel;
            gnt_id <= sel;
            busy   <= 1'b1;
            cnt    <= CW'(1);
            last   <= sel;
          end
        end
        OWNED: begin
          if (hold) begin
            cnt <= cnt + CW'(1);
          end else if (sel_vld) begin
            gnt    <= N'(1) << sel;
            gnt_id <= sel;
            cnt    <= CW'(1);
            last   <= sel;
          end else begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT    = gnt;
  assign bus.GNT_ID = gnt_id;
  assign bus.BUSY   = busy;
endmodule

// File: tb/tb_round_robin_burst_arbiter.sv
// Randomized and directed bench for round_robin_burst_arbiter
// against a queue-free behavioural ownership model.
module tb_round_robin_burst_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk;
  logic rstn;

  round_robin_burst_arbiter_if #(.N(N)) bus ();

  round_robin_burst_arbiter #(
    .N(N),
    .MAX_BURST(MB)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  int checks;
  int errors;

  int m_owner;
  int m_last;
  int m_burst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int exp_gnt();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  function automatic int exp_id();
    return (m_owner < 0) ? 0 : m_owner;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_burst = 0;
  endtask

  // owner keeps the resource while requesting and under the burst
  // limit; otherwise the next requester after the last owner wins
  task automatic model_step(input logic [N-1:0] r);
    int pick;
    if (m_owner >= 0 && r[m_owner] && m_burst < MB) begin
      m_burst++;
    end else begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && r[(m_last + k) % N]) pick = (m_last + k) % N;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_last  = pick;
        m_burst = 1;
      end else begin
        m_owner = -1;
        m_burst = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".gnt"},  int'(bus.GNT),    exp_gnt());
    chk({tag, ".id"},   int'(bus.GNT_ID), exp_id());
    chk({tag, ".busy"}, int'(bus.BUSY),   (m_owner >= 0) ? 1 : 0);
    chk({tag, ".onehot"}, int'($countones(bus.GNT) <= 1), 1);
  endtask

  task automatic cycle(input logic [N-1:0] r, input string tag);
    bus.REQ = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #1;
    chk({tag, ".rst_gnt"}, int'(bus.GNT), 0);
    chk({tag, ".rst_id"},  int'(bus.GNT_ID), 0);
    chk({tag, ".rst_busy"}, int'(bus.BUSY), 0);
    model_reset();
    bus.REQ = '1;
    @(posedge clk);
    #1;
    chk({tag, ".rst_hold"}, int'(bus.GNT), 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.REQ = '1;
    model_reset();

    // reset held with all requests active
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_all.gnt",  int'(bus.GNT), 0);
      chk("rst_all.id",   int'(bus.GNT_ID), 0);
      chk("rst_all.busy", int'(bus.BUSY), 0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // single requester, short burst then release
    repeat (3) cycle(4'b0001, "single");
    chk("single.const", int'(bus.GNT), 1);
    cycle(4'b0000, "single_rel");
    chk("single_rel.busy", int'(bus.BUSY), 0);
    cycle(4'b0000, "single_idle");

    // full rotation with all requesting
    do_reset("rot");
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1111, "rot");
      chk("rot.seq", int'(bus.GNT), 1 << ((i / MB) % N));
    end

    // lone requester re-granted across burst boundaries
    do_reset("lone");
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0100, "lone");
      chk("lone.const", int'(bus.GNT), 4);
    end

    // owner drops, handover skips to next eligible
    do_reset("hand");
    cycle(4'b0010, "hand");
    chk("hand.own1", int'(bus.GNT), 2);
    cycle(4'b1001, "hand");
    chk("hand.to3", int'(bus.GNT), 8);
    chk("hand.id3", int'(bus.GNT_ID), 3);
    cycle(4'b0001, "hand");
    chk("hand.to0", int'(bus.GNT), 1);

    // asynchronous reset in the middle of a grant
    do_reset("mid");
    for (int i = 0; i < 9; i++) cycle(4'b1111, "mid");
    chk("mid.own2", int'(bus.GNT), 4);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid.async_gnt", int'(bus.GNT), 0);
    chk("mid.async_busy", int'(bus.BUSY), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    cycle(4'b1111, "mid_post");
    chk("mid.first0", int'(bus.GNT), 1);

    // randomized traffic with occasional resets
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd");
      end
      case ($urandom_range(0, 3))
        0: r = N'($urandom);
        1: r = '1;
        2: r = N'(1) << $urandom_range(0, N - 1);
        default: r = N'($urandom) & N'($urandom);
      endcase
      cycle(r, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
